obj_linebuf_ctrl: RTL and testbench

//  Ping-pong sprite line-buffer controller: two DPRAM banks, one filled by the sprite renderer, one scanned out.

---
 rtl/obj_pkg.sv | 15 +
 rtl/linebuf_bank.sv | 29 ++
 rtl/obj_linebuf_ctrl.sv | 176 +++++++++++++++++
 tb/tb_obj_linebuf_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/obj_pkg.sv
// Shared definitions for the sprite line-buffer controller: FSM encoding and
// default geometry / pixel-marker values.
package obj_pkg;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam int unsigned AW_DEF     = 10;
   localparam int unsigned DW_DEF     = 8;
   localparam int unsigned TRANSP_DEF = 0;
   localparam int unsigned CLR_DEF    = 0;

endpackage

// File: rtl/linebuf_bank.sv
// One line-buffer bank: true dual-port RAM, port0 registered read,
// port1 write-only. A same-cycle read and write to one address returns the
// old contents; the controller forwards around that case.
module linebuf_bank #(
   parameter int unsigned AW = 10,
   parameter int unsigned DW = 8
) (
   input  logic          cl,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data
);

   logic [DW-1:0] mem [0:(1<<AW)-1];

   // port0: registered read
   always_ff @(posedge cl) begin
      if (rd_en) rd_data <= mem[rd_addr];
   end

   // port1: write
   always_ff @(posedge cl) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

endmodule

// File: rtl/obj_linebuf_ctrl.sv
// Ping-pong sprite line-buffer controller. Bank[sel] is filled by the
// renderer (first opaque pixel wins per x), bank[!sel] is scanned out by the
// display and cleared behind the beam. After reset both banks are swept to
// CLR before normal operation starts.
module obj_linebuf_ctrl
   import obj_pkg::*;
#(
   parameter int unsigned   AW     = AW_DEF,
   parameter int unsigned   DW     = DW_DEF,
   parameter logic [DW-1:0] TRANSP = DW'(TRANSP_DEF),
   parameter logic [DW-1:0] CLR    = DW'(CLR_DEF)
) (
   input  logic          cl,
   input  logic          rst,
   input  logic          lstart,
   input  logic          wr_req,
   input  logic [AW-1:0] wr_x,
   input  logic [DW-1:0] wr_pix,
   output logic          wr_rdy,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_x,
   output logic [DW-1:0] rd_pix,
   output logic          init_busy
);

   state_t        state, state_nxt;
   logic          sweep, run;
   logic [AW-1:0] cnt;
   logic          sel;

   // write pipeline
   logic          s0_acc, s0_fwd;
   logic          s1_vld, s1_bank, s1_fwd, s1_commit;
   logic [AW-1:0] s1_x;
   logic [DW-1:0] s1_pix;

   // read/clear pipeline
   logic          r0_acc, r0_fwd;
   logic          r1_vld, r1_bank, r1_fwd;
   logic [AW-1:0] r1_x;

   // bank ports
   logic [1:0]          p0_en;
   logic [1:0][AW-1:0]  p0_addr;
   logic [1:0]          p1_en;
   logic [1:0][AW-1:0]  p1_addr;
   logic [1:0][DW-1:0]  p1_data;
   logic [DW-1:0]       bank_q [2];

   // FSM state register
   always_ff @(posedge cl) begin
      if (rst) state <= ST_INIT;
      else     state <= state_nxt;
   end

   // FSM next state: sweep finishes once the last address has been written
   always_comb begin
      state_nxt = state;
      case (state)
         ST_INIT: if (cnt == '1) state_nxt = ST_RUN;
         ST_RUN:  state_nxt = ST_RUN;
         default: state_nxt = ST_INIT;
      endcase
   end

   // FSM outputs
   always_comb begin
      sweep = 1'b0;
      run   = 1'b0;
      case (state)
         ST_INIT: sweep = 1'b1;
         ST_RUN:  run   = 1'b1;
         default: sweep = 1'b1;
      endcase
   end

   assign init_busy = sweep;
   // the swap cycle is dead for writes so no S0 straddles a bank change
   assign wr_rdy    = run & ~lstart;
   assign s0_acc    = wr_req & wr_rdy;
   assign r0_acc    = run & rd_en;

   // sweep counter, wraps in AW bits
   always_ff @(posedge cl) begin
      if (rst)        cnt <= '0;
      else if (sweep) cnt <= cnt + 1'b1;
   end

   // bank select, toggles on line start once running
   always_ff @(posedge cl) begin
      if (rst)               sel <= 1'b0;
      else if (run & lstart) sel <= ~sel;
   end

   // S1 writes only into an empty slot; the forwarded flag covers a commit
   // to the same slot that raced with this entry's S0 read
   assign s1_commit = s1_vld & ~s1_fwd & (bank_q[s1_bank] == CLR);
   assign s0_fwd    = s1_commit & (s1_bank == sel) & (s1_x == wr_x);
   assign r0_fwd    = r1_vld & (r1_bank == ~sel) & (r1_x == rd_x);

   // S0 -> S1 register; transparent pixels never become valid
   always_ff @(posedge cl) begin
      if (rst) begin
         s1_vld <= 1'b0;
      end else begin
         s1_vld <= s0_acc & (wr_pix != TRANSP);
         if (s0_acc) begin
            s1_x    <= wr_x;
            s1_pix  <= wr_pix;
            s1_bank <= sel;
            s1_fwd  <= s0_fwd;
         end
      end
   end

   // R0 -> R1 register
   always_ff @(posedge cl) begin
      if (rst) begin
         r1_vld <= 1'b0;
      end else begin
         r1_vld <= r0_acc;
         if (r0_acc) begin
            r1_x    <= rd_x;
            r1_bank <= ~sel;
            r1_fwd  <= r0_fwd;
         end
      end
   end

   // display pixel: back-to-back reads of one x see the clear already done
   always_ff @(posedge cl) begin
      if (rst)         rd_pix <= CLR;
      else if (sweep)  rd_pix <= CLR;
      else if (r1_vld) rd_pix <= r1_fwd ? CLR : bank_q[r1_bank];
   end

   // port muxes: port0 serves S0 on the write bank and R0 on the read bank;
   // port1 serves the sweep, else the S1 commit or R1 clear of its bank
   always_comb begin
      for (int b = 0; b < 2; b++) begin
         p0_en[b]   = (sel == 1'(b)) ? s0_acc : r0_acc;
         p0_addr[b] = (sel == 1'(b)) ? wr_x   : rd_x;
         p1_en[b]   = 1'b0;
         p1_addr[b] = r1_x;
         p1_data[b] = CLR;
         if (sweep) begin
            p1_en[b]   = 1'b1;
            p1_addr[b] = cnt;
         end else if (s1_commit && (s1_bank == 1'(b))) begin
            p1_en[b]   = 1'b1;
            p1_addr[b] = s1_x;
            p1_data[b] = s1_pix;
         end else if (r1_vld && (r1_bank == 1'(b))) begin
            p1_en[b]   = 1'b1;
            p1_addr[b] = r1_x;
         end
         if (rst) p1_en[b] = 1'b0;
      end
   end

   for (genvar g = 0; g < 2; g++) begin : g_bank
      linebuf_bank #(
         .AW(AW),
         .DW(DW)
      ) u_bank (
         .cl      (cl),
         .rd_en   (p0_en[g]),
         .rd_addr (p0_addr[g]),
         .rd_data (bank_q[g]),
         .wr_en   (p1_en[g]),
         .wr_addr (p1_addr[g]),
         .wr_data (p1_data[g])
      );
   end

endmodule

// File: tb/tb_obj_linebuf_ctrl.sv
// Bench for obj_linebuf_ctrl: directed scenarios followed by random traffic,
// all checked against a transaction-level model of two line arrays.
module tb_obj_linebuf_ctrl;

   localparam int AW = 4;
   localparam int DW = 8;
   localparam int N  = 1 << AW;

   logic          cl = 1'b0;
   logic          rst = 1'b0;
   logic          lstart = 1'b0;
   logic          wr_req = 1'b0;
   logic [AW-1:0] wr_x = '0;
   logic [DW-1:0] wr_pix = '0;
   logic          wr_rdy;
   logic          rd_en = 1'b0;
   logic [AW-1:0] rd_x = '0;
   logic [DW-1:0] rd_pix;
   logic          init_busy;

   int n_tests = 0;
   int n_fail  = 0;

   obj_linebuf_ctrl #(
      .AW(AW), .DW(DW), .TRANSP(8'h00), .CLR(8'h00)
   ) dut (
      .cl(cl), .rst(rst), .lstart(lstart),
      .wr_req(wr_req), .wr_x(wr_x), .wr_pix(wr_pix), .wr_rdy(wr_rdy),
      .rd_en(rd_en), .rd_x(rd_x), .rd_pix(rd_pix), .init_busy(init_busy)
   );

   always #5 cl = ~cl;

   // reference model: two line arrays, write-bank index, sweep countdown
   logic [DW-1:0] mb [2][N];
   int            wsel;
   int            init_left;
   bit            model_valid = 1'b0;
   bit            pend_v;
   logic [DW-1:0] pend_d;
   logic [DW-1:0] exp_rd;
   logic          wr_rdy_seen;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // one clock: drive inputs, check combinational outputs, clock, update model, check rd_pix
   task automatic step(input bit r, input bit ls, input bit wq, input int wx, input int wp,
                       input bit re, input int rx);
      bit run_now, acc;
      int wi, ri;
      rst = r; lstart = ls; wr_req = wq; rd_en = re;
      wr_x = wx[AW-1:0]; wr_pix = wp[DW-1:0]; rd_x = rx[AW-1:0];
      wi = wx & (N - 1);
      ri = rx & (N - 1);
      #1;
      run_now = model_valid && (init_left == 0);
      wr_rdy_seen = wr_rdy;
      if (!r && model_valid) begin
         check("init_busy", init_busy, !run_now);
         check("wr_rdy", wr_rdy, run_now && !ls);
      end
      acc = wq && run_now && !ls;
      @(posedge cl);
      if (r) begin
         for (int b = 0; b < 2; b++)
            for (int i = 0; i < N; i++) mb[b][i] = '0;
         wsel = 0; init_left = N; pend_v = 1'b0; exp_rd = '0;
         model_valid = 1'b1;
      end else if (model_valid) begin
         if (pend_v) exp_rd = pend_d;
         pend_v = 1'b0;
         if (run_now && re) begin
            pend_v = 1'b1;
            pend_d = mb[1-wsel][ri];
            mb[1-wsel][ri] = '0;
         end
         if (acc && (wp[DW-1:0] != 0) && (mb[wsel][wi] == 0)) mb[wsel][wi] = wp[DW-1:0];
         if (run_now && ls) wsel = 1 - wsel;
         if (init_left > 0) init_left--;
      end
      #1;
      if (model_valid) check("rd_pix", rd_pix, exp_rd);
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      int prx;
      bit ls, wq, re;
      int wx, wp, rx;

      // 1: reset, sweep, everything reads back empty
      step(1, 0, 0, 0, 0, 0, 0);
      check("t1_busy_after_rst", init_busy, 1);
      check("t1_rdpix_after_rst", rd_pix, 0);
      for (int i = 0; i < N; i++) step(0, 1, 1, 5, 8'h99, 1, i);  // ignored during sweep
      check("t1_busy_done", init_busy, 0);
      for (int i = 0; i < N; i++) step(0, 0, 0, 0, 0, 1, i);
      step(0, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < N; i++) step(0, 0, 0, 0, 0, 1, i);
      idle();
      check("t1_empty", rd_pix, 0);

      // 2: single write, swap, read, then next visit of that bank is empty
      step(0, 0, 1, 5, 8'h21, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 5);
      idle();
      check("t2_read", rd_pix, 8'h21);
      step(0, 1, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 5);
      idle();
      check("t2_cleared", rd_pix, 0);

      // 3: back-to-back same-x writes, first opaque wins
      step(0, 0, 1, 7, 8'h33, 0, 0);
      step(0, 0, 1, 7, 8'h44, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 7);
      idle();
      check("t3_first_wins", rd_pix, 8'h33);

      // 4: transparent pixel leaves location empty
      step(0, 0, 1, 3, 8'h00, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 3);
      idle();
      check("t4_transp", rd_pix, 0);

      // 5: write just before swap, read on swap cycle hits old read bank
      step(0, 0, 1, 9, 8'h55, 0, 0);
      step(0, 1, 1, 9, 8'h66, 1, 9);
      check("t5_wr_rdy_swap", wr_rdy_seen, 0);
      idle();
      check("t5_old_bank", rd_pix, 0);
      step(0, 0, 0, 0, 0, 1, 9);
      step(0, 0, 0, 0, 0, 1, 9);
      check("t5_new_bank", rd_pix, 8'h55);
      idle();
      check("t5_same_x_again", rd_pix, 0);

      // 6: reset with S1 and R1 in flight
      step(0, 0, 1, 2, 8'h66, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0);
      step(0, 0, 1, 8, 8'h77, 1, 2);
      step(0, 0, 1, 9, 8'h12, 1, 3);
      check("t6_before_rst", rd_pix, 8'h66);
      step(1, 0, 0, 0, 0, 0, 0);
      check("t6_rdpix_rst", rd_pix, 0);
      for (int i = 0; i < N; i++) idle();
      check("t6_busy_done", init_busy, 0);

      // random traffic against the model
      prx = 0;
      for (int k = 0; k < 3000; k++) begin
         ls = ($urandom_range(0, 11) == 0);
         wq = ($urandom_range(0, 2) != 0);
         wx = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, N - 1));
         wp = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
         re = ($urandom_range(0, 1) == 0);
         rx = ($urandom_range(0, 3) == 0) ? prx : int'($urandom_range(0, N - 1));
         prx = rx;
         if (k == 1500) step(1, ls, wq, wx, wp, re, rx);
         else           step(0, ls, wq, wx, wp, re, rx);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
